// File: rtl/name_entry_pkg.sv
// Shared definitions for the high-score path: name entry, scoreboard and display.
// Holds the letter/score geometry and the name-entry state encodings.
package name_entry_pkg;

    localparam int ALPHABET_SIZE = 5;    // bits per letter code
    localparam int SCORE_SIZE    = 16;   // score width
    localparam int NAME_LEN      = 3;    // letters per name
    localparam int LETTER_COUNT  = 26;   // valid codes 0..LETTER_COUNT-1, 0 = 'A'

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ENTRY  = 2'd1,
        COMMIT = 2'd2
    } state_t;

endpackage

// File: rtl/name_entry_timer.sv
// Idle timer for the initials-entry session.
// Counts cycles while not cleared, saturating at TIMEOUT_CYCLES-1, and raises
// o_timeout while the count sits at that value.
// Ports:
//   clk       in   system clock
//   rst       in   asynchronous active-low reset
//   i_clear   in   synchronous clear (button activity or not in entry)
//   o_timeout out  high while the count equals TIMEOUT_CYCLES-1
module name_entry_timer #(
    parameter int TIMEOUT_CYCLES = 1_000_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    output logic o_timeout
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (r_count != LAST_COUNT) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_timeout = (r_count == LAST_COUNT);

endmodule

// File: rtl/name_entry.sv
// Initials-entry front end for the high-score scoreboard.
// A game_over pulse with a score above the current 5th place opens a 3-letter
// entry session driven by button pulses; the session ends with a one-cycle
// insert of {score, initials}. Non-qualifying scores produce a skipped pulse.
// Ports:
//   clk, rst                        clock, asynchronous active-low reset
//   game_over, final_score          end-of-game pulse and its score
//   lowest_score                    current 5th-place score
//   btn_up/down/confirm/back        debounced single-cycle button pulses
//   entering, cursor, edit_string   live session state for the display
//   skipped                         pulse: score did not qualify
//   insert, new_score, new_string   commit to the scoreboard (held after insert)
module name_entry #(
    parameter int ALPHABET_SIZE  = name_entry_pkg::ALPHABET_SIZE,
    parameter int LETTER_COUNT   = name_entry_pkg::LETTER_COUNT,
    parameter int SCORE_SIZE     = name_entry_pkg::SCORE_SIZE,
    parameter int TIMEOUT_CYCLES = 1_000_000_000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       game_over,
    input  logic [SCORE_SIZE-1:0]      final_score,
    input  logic [SCORE_SIZE-1:0]      lowest_score,
    input  logic                       btn_up,
    input  logic                       btn_down,
    input  logic                       btn_confirm,
    input  logic                       btn_back,
    output logic                       entering,
    output logic [1:0]                 cursor,
    output logic [3*ALPHABET_SIZE-1:0] edit_string,
    output logic                       skipped,
    output logic                       insert,
    output logic [SCORE_SIZE-1:0]      new_score,
    output logic [3*ALPHABET_SIZE-1:0] new_string
);

    import name_entry_pkg::*;

    localparam logic [ALPHABET_SIZE-1:0] LAST_LETTER = ALPHABET_SIZE'(LETTER_COUNT - 1);
    localparam logic [1:0]               LAST_POS    = 2'(NAME_LEN - 1);

    state_t                    r_state, w_state_next;
    logic [ALPHABET_SIZE-1:0]  r_letters [NAME_LEN];
    logic [ALPHABET_SIZE-1:0]  w_letters_next [NAME_LEN];
    logic [1:0]                r_cursor, w_cursor_next;
    logic [SCORE_SIZE-1:0]     r_score, w_score_next;
    logic                      w_skipped_next;
    logic                      r_entering, r_skipped, r_insert;
    logic [SCORE_SIZE-1:0]     r_new_score;
    logic [3*ALPHABET_SIZE-1:0] r_new_string, w_packed;
    logic                      w_any_btn, w_timeout, w_timer_clear;

    // Letter 0 (first entered) occupies the most significant field.
    for (genvar gi = 0; gi < NAME_LEN; gi++) begin : g_pack
        assign w_packed[(NAME_LEN-1-gi)*ALPHABET_SIZE +: ALPHABET_SIZE] = r_letters[gi];
    end

    assign w_any_btn     = btn_up | btn_down | btn_confirm | btn_back;
    // Held clear outside ENTRY so every session starts from zero.
    assign w_timer_clear = (r_state != ENTRY) || w_any_btn;

    name_entry_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_timer_clear),
        .o_timeout(w_timeout)
    );

    always_comb begin
        w_state_next   = r_state;
        w_cursor_next  = r_cursor;
        w_score_next   = r_score;
        w_skipped_next = 1'b0;
        for (int i = 0; i < NAME_LEN; i++) begin
            w_letters_next[i] = r_letters[i];
        end

        case (r_state)
            IDLE: begin
                if (game_over) begin
                    w_score_next = final_score;
                    if (final_score > lowest_score) begin
                        w_state_next  = ENTRY;
                        w_cursor_next = '0;
                        for (int i = 0; i < NAME_LEN; i++) begin
                            w_letters_next[i] = '0;
                        end
                    end else begin
                        w_skipped_next = 1'b1;
                    end
                end
            end
            ENTRY: begin
                // One action per cycle: confirm > back > up > down > timeout.
                if (btn_confirm) begin
                    if (r_cursor == LAST_POS) begin
                        w_state_next = COMMIT;
                    end else begin
                        w_cursor_next = r_cursor + 2'd1;
                    end
                end else if (btn_back) begin
                    if (r_cursor != 2'd0) begin
                        w_cursor_next = r_cursor - 2'd1;
                    end
                end else if (btn_up || btn_down) begin
                    for (int i = 0; i < NAME_LEN; i++) begin
                        if (r_cursor == 2'(i)) begin
                            if (btn_up) begin
                                w_letters_next[i] = (r_letters[i] == LAST_LETTER) ?
                                    '0 : r_letters[i] + ALPHABET_SIZE'(1);
                            end else begin
                                w_letters_next[i] = (r_letters[i] == '0) ?
                                    LAST_LETTER : r_letters[i] - ALPHABET_SIZE'(1);
                            end
                        end
                    end
                end else if (w_timeout) begin
                    w_state_next = COMMIT;
                end
            end
            COMMIT: begin
                w_state_next  = IDLE;
                w_cursor_next = '0;
            end
            default: begin
                w_state_next  = IDLE;
                w_cursor_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_cursor     <= '0;
            r_score      <= '0;
            r_entering   <= 1'b0;
            r_skipped    <= 1'b0;
            r_insert     <= 1'b0;
            r_new_score  <= '0;
            r_new_string <= '0;
            for (int i = 0; i < NAME_LEN; i++) begin
                r_letters[i] <= '0;
            end
        end else begin
            r_state    <= w_state_next;
            r_cursor   <= w_cursor_next;
            r_score    <= w_score_next;
            r_skipped  <= w_skipped_next;
            r_entering <= (w_state_next == ENTRY);
            r_insert   <= (w_state_next == COMMIT);
            for (int i = 0; i < NAME_LEN; i++) begin
                r_letters[i] <= w_letters_next[i];
            end
            // Letters do not change on the edge that enters COMMIT, so the
            // current packing is the final name.
            if (w_state_next == COMMIT) begin
                r_new_score  <= r_score;
                r_new_string <= w_packed;
            end
        end
    end

    assign entering    = r_entering;
    assign cursor      = r_cursor;
    assign edit_string = w_packed;
    assign skipped     = r_skipped;
    assign insert      = r_insert;
    assign new_score   = r_new_score;
    assign new_string  = r_new_string;

endmodule
